// File: rtl/latch_serial_tx_shift_reg_load.sv
// rtl/latch_serial_tx_shift_reg_load.sv - WIDTH-bit parallel-load shift register feeding the serial transmitter
module latch_serial_tx_shift_reg_load #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_i,
    output logic             head_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = data_i;
        end else if (shift_i) begin
            data_d = MSB_FIRST ? {data_q[WIDTH-2:0], 1'b0} : {1'b0, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    // Head is the bit that leaves next, at whichever end the direction selects.
    assign head_o = MSB_FIRST ? data_q[WIDTH-1] : data_q[0];

endmodule

// File: rtl/latch_serial_tx.sv
// rtl/latch_serial_tx.sv - serial driver for a level-sensitive latch: data set up a cycle before each enable-high window
module latch_serial_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    output logic             ready,
    output logic             q,
    output logic             q_bar,
    output logic             le,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SETUP = 2'b01,
        HOLD  = 2'b10,
        DONE  = 2'b11
    } state_e;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q_q;
    logic             le_q;
    logic             ready_q;
    logic             done_q;

    logic sr_load;
    logic sr_shift;
    logic sr_head;
    logic first_bit;

    assign sr_load   = (state_q == IDLE) && load;
    // Shifting as SETUP hands over to HOLD leaves the next bit at the head in time for the HOLD exit.
    assign sr_shift  = (state_q == SETUP);
    assign first_bit = MSB_FIRST ? d_in[WIDTH-1] : d_in[0];

    latch_serial_tx_shift_reg_load #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .load_i  (sr_load),
        .data_i  (d_in),
        .shift_i (sr_shift),
        .head_o  (sr_head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            le_q    <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= SETUP;
                        cnt_q   <= '0;
                        q_q     <= first_bit;
                        ready_q <= 1'b0;
                    end
                end
                SETUP: begin
                    state_q <= HOLD;
                    le_q    <= 1'b1;
                end
                HOLD: begin
                    le_q <= 1'b0;
                    if (cnt_q == LAST_BIT) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        q_q     <= 1'b0;
                    end else begin
                        state_q <= SETUP;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        q_q     <= sr_head;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign q     = q_q;
    assign q_bar = ~q_q;
    assign le    = le_q;
    assign ready = ready_q;
    assign done  = done_q;

endmodule

// File: tb/tb_latch_serial_tx.sv
// tb/tb_latch_serial_tx.sv - directed scoreboard bench for latch_serial_tx in both shift directions
module tb_latch_serial_tx;

    logic       clk;
    logic       reset_n;
    logic       load_m, load_l;
    logic [7:0] d_m, d_l;
    logic       ready_m, q_m, qb_m, le_m, done_m;
    logic       ready_l, q_l, qb_l, le_l, done_l;

    int total = 0;
    int bad   = 0;
    int done_cnt_m = 0;
    int done_cnt_l = 0;
    logic prev_q_m = 1'b0;
    logic prev_q_l = 1'b0;
    logic latch_q  = 1'b0;
    logic exp_bits_m[$];
    logic exp_bits_l[$];

    latch_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset_n(reset_n), .load(load_m), .d_in(d_m),
        .ready(ready_m), .q(q_m), .q_bar(qb_m), .le(le_m), .done(done_m)
    );

    latch_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset_n(reset_n), .load(load_l), .d_in(d_l),
        .ready(ready_l), .q(q_l), .q_bar(qb_l), .le(le_l), .done(done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input bit msb_first, input bit to_m);
        for (int i = 0; i < 8; i++) begin
            if (to_m) exp_bits_m.push_back(msb_first ? d[7-i] : d[i]);
            else      exp_bits_l.push_back(msb_first ? d[7-i] : d[i]);
        end
    endtask

    task automatic tick();
        logic e;
        @(posedge clk);
        #1;
        chk("qbar_m", {31'b0, qb_m}, {31'b0, ~q_m});
        chk("qbar_l", {31'b0, qb_l}, {31'b0, ~q_l});
        if (le_m) begin
            chk("stable_m", {31'b0, q_m}, {31'b0, prev_q_m});
            latch_q = q_m;
            if (exp_bits_m.size() == 0) begin
                chk("sb_empty_m", 32'd1, 32'd0);
            end else begin
                e = exp_bits_m.pop_front();
                chk("bit_m", {31'b0, q_m}, {31'b0, e});
                chk("latch", {31'b0, latch_q}, {31'b0, e});
            end
        end
        if (le_l) begin
            chk("stable_l", {31'b0, q_l}, {31'b0, prev_q_l});
            if (exp_bits_l.size() == 0) begin
                chk("sb_empty_l", 32'd1, 32'd0);
            end else begin
                e = exp_bits_l.pop_front();
                chk("bit_l", {31'b0, q_l}, {31'b0, e});
            end
        end
        if (done_m) done_cnt_m++;
        if (done_l) done_cnt_l++;
        prev_q_m = q_m;
        prev_q_l = q_l;
    endtask

    // Accepts a frame on dut_m at edge 0, then walks edges 1..17 checking done/ready timing.
    task automatic frame_m(input logic [7:0] d);
        int d0;
        d0 = done_cnt_m;
        d_m = d; load_m = 1'b1;
        push_frame(d, 1'b1, 1'b1);
        tick();
        load_m = 1'b0;
        chk("ready_busy_m", {31'b0, ready_m}, 32'd0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk("done_t_m", {31'b0, done_m}, {31'b0, (k == 16)});
            chk("ready_t_m", {31'b0, ready_m}, {31'b0, (k == 17)});
        end
        chk("sb_drained_m", exp_bits_m.size(), 32'd0);
        chk("done_once_m", done_cnt_m - d0, 32'd1);
    endtask

    initial begin
        int d0;
        reset_n = 1'b0; load_m = 1'b0; load_l = 1'b0; d_m = '0; d_l = '0;
        tick(); tick();
        chk("rst_ready", {31'b0, ready_m}, 32'd1);
        chk("rst_q",     {31'b0, q_m},     32'd0);
        chk("rst_qbar",  {31'b0, qb_m},    32'd1);
        chk("rst_le",    {31'b0, le_m},    32'd0);
        chk("rst_done",  {31'b0, done_m},  32'd0);
        reset_n = 1'b1;
        tick();
        chk("idle_ready", {31'b0, ready_m}, 32'd1);

        // MSB-first A5
        frame_m(8'hA5);

        // LSB-first 01
        d0 = done_cnt_l;
        d_l = 8'h01; load_l = 1'b1;
        push_frame(8'h01, 1'b0, 1'b0);
        tick();
        load_l = 1'b0;
        chk("first_bit_l", {31'b0, q_l}, 32'd1);
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk("done_t_l", {31'b0, done_l}, {31'b0, (k == 16)});
            chk("ready_t_l", {31'b0, ready_l}, {31'b0, (k == 17)});
        end
        chk("sb_drained_l", exp_bits_l.size(), 32'd0);
        chk("done_once_l", done_cnt_l - d0, 32'd1);

        // Busy rejection: extra loads at edges 3 and 16
        d0 = done_cnt_m;
        d_m = 8'hF0; load_m = 1'b1;
        push_frame(8'hF0, 1'b1, 1'b1);
        tick();
        load_m = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            load_m = (k == 3 || k == 16);
            d_m = (k == 3 || k == 16) ? 8'h0F : 8'hF0;
            tick();
            load_m = 1'b0;
            chk("rej_done", {31'b0, done_m}, {31'b0, (k == 16)});
            chk("rej_ready", {31'b0, ready_m}, {31'b0, (k == 17)});
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rej_no_frame", {30'b0, le_m, ready_m}, 32'd1);
        end
        chk("rej_sb", exp_bits_m.size(), 32'd0);
        chk("rej_done_cnt", done_cnt_m - d0, 32'd1);

        // Mid-frame asynchronous reset
        d0 = done_cnt_m;
        d_m = 8'hFF; load_m = 1'b1;
        push_frame(8'hFF, 1'b1, 1'b1);
        tick();
        load_m = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_q",     {31'b0, q_m},     32'd0);
        chk("mid_rst_qbar",  {31'b0, qb_m},    32'd1);
        chk("mid_rst_le",    {31'b0, le_m},    32'd0);
        chk("mid_rst_ready", {31'b0, ready_m}, 32'd1);
        chk("mid_rst_done",  {31'b0, done_m},  32'd0);
        exp_bits_m.delete();
        tick(); tick();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("mid_rst_no_done", done_cnt_m - d0, 32'd0);
        frame_m(8'h81);

        // Back-to-back with load held high
        d0 = done_cnt_m;
        d_m = 8'h3C; load_m = 1'b1;
        push_frame(8'h3C, 1'b1, 1'b1);
        push_frame(8'h3C, 1'b1, 1'b1);
        tick();
        for (int k = 1; k <= 35; k++) begin
            tick();
            if (k == 18) load_m = 1'b0;
            chk("b2b_done", {31'b0, done_m}, {31'b0, (k == 16 || k == 34)});
            chk("b2b_ready", {31'b0, ready_m}, {31'b0, (k == 17 || k == 35)});
        end
        chk("b2b_sb", exp_bits_m.size(), 32'd0);
        chk("b2b_done_cnt", done_cnt_m - d0, 32'd2);

        // Latch integration: C3 ends with latch holding 1
        latch_q = 1'b0;
        frame_m(8'hC3);
        chk("latch_final", {31'b0, latch_q}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
